// File: rtl/echo_multi.sv
// Echo/reverb stage: ring-buffer delay line with shifter attenuation and saturating mix.
// The buffer is zero-flushed after reset and after every delay change.
module echo_multi #(
   parameter int WIDTH      = 16,
   parameter int ADDR_W     = 15,
   parameter int DELAY_STEP = 4800,
   parameter int NUM_DELAYS = 5,
   parameter int ATT_W      = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] sample_in,
   input  logic             in_ready,
   input  logic             next_D,
   input  logic             next_H,
   input  logic             mode_fb,
   input  logic             bypass,
   output logic [WIDTH-1:0] out,
   output logic             out_ready,
   output logic             busy
);

   localparam int IDX_W = (NUM_DELAYS > 1) ? $clog2(NUM_DELAYS) : 1;
   localparam int SH_W  = ATT_W + 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_DELAYS - 1);
   localparam logic signed [WIDTH:0] MAX_V = {2'b00, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH:0] MIN_V = {2'b11, {(WIDTH-1){1'b0}}};

   typedef enum logic {FLUSH, RUN} state_t;

   state_t                   state;
   logic [IDX_W-1:0]         delay_idx;
   logic [ATT_W-1:0]         att_idx;
   logic [ADDR_W-1:0]        wp;
   logic [ADDR_W-1:0]        flush_cnt;
   logic [ADDR_W-1:0]        delay;
   logic [ADDR_W-1:0]        ra;

   logic signed [WIDTH-1:0]  mem [2**ADDR_W];
   logic signed [WIDTH-1:0]  rd_p0;
   logic signed [WIDTH-1:0]  sample_p0;
   logic                     fb_p0;
   logic                     byp_p0;
   logic                     dry_p0;
   logic [SH_W-1:0]          shift_p0;
   logic                     vld_p0;

   logic signed [WIDTH-1:0]  echo;
   logic signed [WIDTH:0]    sum;
   logic signed [WIDTH-1:0]  mix;
   logic                     we;
   logic [ADDR_W-1:0]        wa;
   logic signed [WIDTH-1:0]  wd;

   function automatic logic signed [WIDTH-1:0] sat(input logic signed [WIDTH:0] v);
      if (v > MAX_V)
         return MAX_V[WIDTH-1:0];
      else if (v < MIN_V)
         return MIN_V[WIDTH-1:0];
      else
         return v[WIDTH-1:0];
   endfunction

   assign delay = ADDR_W'((int'(delay_idx) + 1) * DELAY_STEP);
   assign ra    = wp - delay;

   // Stage p0 -> output: attenuate the delayed sample, mix, and arbitrate the write port
   always_comb begin
      echo = rd_p0 >>> shift_p0;
      if (dry_p0 || state == FLUSH)
         echo = '0;
      sum = {sample_p0[WIDTH-1], sample_p0} + {echo[WIDTH-1], echo};
      mix = sat(sum);
      we  = 1'b0;
      wa  = wp;
      wd  = fb_p0 ? mix : sample_p0;
      if (state == FLUSH) begin
         we = 1'b1;
         wa = flush_cnt;
         wd = '0;
      end else if (vld_p0) begin
         we = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (we)
         mem[wa] <= wd;
      rd_p0 <= mem[ra];
      if (in_ready) begin
         sample_p0 <= sample_in;
         fb_p0     <= mode_fb;
         byp_p0    <= bypass;
         dry_p0    <= (state == FLUSH);
         shift_p0  <= SH_W'(att_idx) + SH_W'(mode_fb);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= FLUSH;
         busy      <= 1'b1;
         flush_cnt <= '0;
         delay_idx <= '0;
         att_idx   <= '0;
         wp        <= '0;
         vld_p0    <= 1'b0;
         out       <= '0;
         out_ready <= 1'b0;
      end else begin
         vld_p0    <= in_ready;
         out_ready <= vld_p0;
         if (vld_p0)
            out <= byp_p0 ? sample_p0 : mix;
         if (vld_p0 && state == RUN)
            wp <= wp + 1'b1;
         if (next_H)
            att_idx <= att_idx + 1'b1;
         // A delay change wins over flush completion and always restarts from address 0
         if (next_D) begin
            delay_idx <= (delay_idx == LAST_IDX) ? '0 : delay_idx + 1'b1;
            flush_cnt <= '0;
            state     <= FLUSH;
            busy      <= 1'b1;
         end else if (state == FLUSH) begin
            flush_cnt <= flush_cnt + 1'b1;
            if (flush_cnt == LAST_ADDR) begin
               state <= RUN;
               busy  <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_echo_multi.sv
// Scoreboard bench for echo_multi on a shrunken buffer (64 samples, 8-sample delay step).
module tb_echo_multi;

   localparam int W     = 16;
   localparam int AW    = 6;
   localparam int STEP  = 8;
   localparam int ND    = 5;
   localparam int ATW   = 2;
   localparam int DEPTH = 1 << AW;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic [W-1:0] sample_in = '0;
   logic         in_ready = 1'b0;
   logic         next_D = 1'b0;
   logic         next_H = 1'b0;
   logic         mode_fb = 1'b0;
   logic         bypass = 1'b0;
   logic [W-1:0] out;
   logic         out_ready;
   logic         busy;

   always #5 clk = ~clk;

   echo_multi #(
      .WIDTH(W), .ADDR_W(AW), .DELAY_STEP(STEP), .NUM_DELAYS(ND), .ATT_W(ATW)
   ) dut (
      .clk(clk), .reset_n(reset_n), .sample_in(sample_in), .in_ready(in_ready),
      .next_D(next_D), .next_H(next_H), .mode_fb(mode_fb), .bypass(bypass),
      .out(out), .out_ready(out_ready), .busy(busy)
   );

   int n_chk = 0;
   int n_err = 0;

   // Reference state: buffer contents, write pointer, indices, remaining flush cycles
   int mmem [DEPTH];
   int wp_m, didx_m, att_m, flush_rem;
   int exp_q [$];

   task automatic check(input string tag, input logic signed [31:0] act, input logic signed [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   function automatic int sat_m(input int v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   task automatic clear_model();
      for (int i = 0; i < DEPTH; i++) mmem[i] = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (flush_rem > 0) flush_rem--;
   endtask

   task automatic send(input int s, input bit fb, input bit byp);
      int ra, d, e, mix, sh;
      bit fl_t, fl_t1;
      sample_in = W'(s);
      mode_fb   = fb;
      bypass    = byp;
      in_ready  = 1'b1;
      fl_t = (flush_rem > 0);
      ra   = (wp_m - (didx_m + 1) * STEP) & (DEPTH - 1);
      sh   = att_m + int'(fb);
      d    = mmem[ra];
      tick();
      in_ready = 1'b0;
      fl_t1 = (flush_rem > 0);
      e   = (fl_t || fl_t1) ? 0 : (d >>> sh);
      mix = sat_m(s + e);
      if (!fl_t1) begin
         mmem[wp_m] = fb ? mix : s;
         wp_m = (wp_m + 1) & (DEPTH - 1);
      end
      exp_q.push_back(byp ? s : mix);
      tick();
      tick();
   endtask

   task automatic pulse_d();
      next_D = 1'b1;
      tick();
      next_D = 1'b0;
      flush_rem = DEPTH;
      didx_m = (didx_m + 1) % ND;
      clear_model();
   endtask

   task automatic pulse_h();
      next_H = 1'b1;
      tick();
      next_H = 1'b0;
      att_m = (att_m + 1) % (1 << ATW);
   endtask

   task automatic wait_flush(input string tag);
      int n;
      n = 0;
      while (flush_rem > 0 && n < 4 * DEPTH) begin
         tick();
         n++;
      end
      check(tag, busy, 0);
   endtask

   always @(negedge clk) begin
      if (reset_n && out_ready) begin
         if (exp_q.size() == 0)
            check("spurious_out_ready", out_ready, 0);
         else
            check("out", $signed(out), exp_q.pop_front());
      end
   end

   initial begin
      int n;
      clear_model();
      wp_m = 0; didx_m = 0; att_m = 0; flush_rem = 0;

      #12;
      check("rst_out", out, 0);
      check("rst_out_ready", out_ready, 0);
      check("rst_busy", busy, 1);

      // Initial flush length
      reset_n = 1'b1;
      flush_rem = DEPTH;
      n = 0;
      while (busy && n < 200) begin
         tick();
         n++;
      end
      check("flush_len", n, DEPTH);
      check("flush_done_busy", busy, 0);

      // Buffer reads back as zero, then impulse with single echo
      for (int i = 0; i < STEP; i++) send(0, 1'b0, 1'b0);
      send(1000, 1'b0, 1'b0);
      for (int i = 0; i < 2 * STEP + 1; i++) send(0, 1'b0, 1'b0);

      // Feedback decaying repeats
      send(8000, 1'b1, 1'b0);
      for (int i = 0; i < 3 * STEP + 2; i++) send(0, 1'b1, 1'b0);

      // Bypass passes dry sample while still feeding the buffer
      send(-1234, 1'b0, 1'b1);
      for (int i = 0; i < STEP; i++) send(0, 1'b0, 1'b0);

      // Saturation at both rails
      for (int i = 0; i < 2 * STEP; i++) send(30000, 1'b0, 1'b0);
      for (int i = 0; i < 2 * STEP; i++) send(-30000, 1'b0, 1'b0);

      // Attenuation index 1, then wrap back to 0
      pulse_h();
      send(4000, 1'b0, 1'b0);
      for (int i = 0; i < STEP; i++) send(-4000, 1'b0, 1'b0);
      send(4000, 1'b1, 1'b0);
      for (int i = 0; i < STEP; i++) send(0, 1'b1, 1'b0);
      pulse_h(); pulse_h(); pulse_h();

      // Delay change mid-stream: busy next cycle, dry outputs, new delay afterwards
      send(2222, 1'b0, 1'b0);
      pulse_d();
      check("nextD_busy", busy, 1);
      for (int i = 0; i < 5; i++) send(1234 + i, 1'b0, 1'b0);
      wait_flush("nextD_flush_done");
      send(5000, 1'b0, 1'b0);
      for (int i = 0; i < 2 * STEP + 1; i++) send(0, 1'b0, 1'b0);

      // Delay change during a flush restarts it from address 0
      pulse_d();
      repeat (5) tick();
      pulse_d();
      while (flush_rem > 1) tick();
      check("restart_still_busy", busy, 1);
      tick();
      check("restart_done", busy, 0);
      send(-7000, 1'b0, 1'b0);
      for (int i = 0; i < 4 * STEP + 1; i++) send(100, 1'b0, 1'b0);

      // Reset between in_ready and out_ready drops the transaction
      sample_in = W'(7777);
      bypass = 1'b0;
      mode_fb = 1'b0;
      in_ready = 1'b1;
      tick();
      in_ready = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      check("midrst_out_ready", out_ready, 0);
      check("midrst_out", out, 0);
      check("midrst_busy", busy, 1);
      tick();
      check("midrst_held_out_ready", out_ready, 0);
      tick();
      reset_n = 1'b1;
      clear_model();
      wp_m = 0; didx_m = 0; att_m = 0;
      flush_rem = DEPTH;
      check("postrst_busy", busy, 1);
      wait_flush("postrst_flush_done");
      send(3000, 1'b0, 1'b0);
      for (int i = 0; i < STEP; i++) send(0, 1'b0, 1'b0);

      repeat (4) tick();
      check("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
